// File: rtl/cov_mean_axil_acc.sv
`default_nettype none
// ============================================================================
//  Module   : cov_mean_axil_acc
//  Purpose  : AXI4-Lite slave register file for the Cov_Mean coprocessor.
//             It accumulates pairs of signed samples into COUNT, SUM_X,
//             SUM_Y and SUM_XY. Software derives mean and covariance from
//             these values.
//  Ports    : S_AXI_ACLK / S_AXI_ARESETN  - clock, async active-low reset
//             S_AXI_AW* / S_AXI_W* / S_AXI_B* - write address/data/response
//             S_AXI_AR* / S_AXI_R*          - read address/data
//  Option   : `define COV_MEAN_SUMSQ_EN adds SUM_XX (0x20) and SUM_YY (0x24).
//             That build needs C_S_AXI_ADDR_WIDTH = 6.
//  Revision : 1.0 - initial release
// ============================================================================
module cov_mean_axil_acc #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
`ifdef COV_MEAN_SUMSQ_EN
   parameter int C_S_AXI_ADDR_WIDTH = 6,
`else
   parameter int C_S_AXI_ADDR_WIDTH = 5,
`endif
   parameter int SAMPLE_WIDTH       = 16
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY
);

   localparam logic [7:0] C_REG_CTRL   = 8'd0;
   localparam logic [7:0] C_REG_STATUS = 8'd1;
   localparam logic [7:0] C_REG_SX     = 8'd2;
   localparam logic [7:0] C_REG_SY     = 8'd3;
   localparam logic [7:0] C_REG_COUNT  = 8'd4;
   localparam logic [7:0] C_REG_SUMX   = 8'd5;
   localparam logic [7:0] C_REG_SUMY   = 8'd6;
   localparam logic [7:0] C_REG_SUMXY  = 8'd7;
`ifdef COV_MEAN_SUMSQ_EN
   localparam logic [7:0] C_REG_SUMXX  = 8'd8;
   localparam logic [7:0] C_REG_SUMYY  = 8'd9;
`endif

   // Two's-complement overflow: both operands have the same sign and the
   // result sign differs from it.
   function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] s);
      return (a[31] == b[31]) && (s[31] != a[31]);
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
      end
      return r;
   endfunction

   // ---------------------------------------------------------------- state
   logic        awready_q, awready_d;
   logic        wready_q,  wready_d;
   logic        bvalid_q,  bvalid_d;
   logic        arready_q, arready_d;
   logic        rvalid_q,  rvalid_d;
   logic [31:0] rdata_q,   rdata_d;
   logic        enable_q,  enable_d;
   logic        ovf_q,     ovf_d;
   logic [31:0] sample_x_q, sample_x_d;
   logic [31:0] sample_y_q, sample_y_d;
   logic [31:0] count_q,   count_d;
   logic [31:0] sum_x_q,   sum_x_d;
   logic [31:0] sum_y_q,   sum_y_d;
   logic [31:0] sum_xy_q,  sum_xy_d;
`ifdef COV_MEAN_SUMSQ_EN
   logic [31:0] sum_xx_q,  sum_xx_d;
   logic [31:0] sum_yy_q,  sum_yy_d;
`endif

   // ---------------------------------------------------------------- datapath
   logic [7:0]  aw_idx, ar_idx;
   logic        wr_en, rd_en, cnt_sat;
   logic [31:0] x_ext, y_ext, xy_prod;
   logic [31:0] sum_x_nxt, sum_y_nxt, sum_xy_nxt;
   logic [31:0] rd_word;
   logic        unused_ok;

   assign aw_idx  = 8'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
   assign ar_idx  = 8'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
   assign cnt_sat = &count_q;

   // The handshake completes on the edge where both READY pulses are seen
   // together with VALID; that edge also updates the register.
   assign wr_en = awready_q && wready_q && S_AXI_AWVALID && S_AXI_WVALID;
   assign rd_en = arready_q && S_AXI_ARVALID;

   assign x_ext = {{(32-SAMPLE_WIDTH){sample_x_q[SAMPLE_WIDTH-1]}},
                   sample_x_q[SAMPLE_WIDTH-1:0]};
   assign y_ext = {{(32-SAMPLE_WIDTH){S_AXI_WDATA[SAMPLE_WIDTH-1]}},
                   S_AXI_WDATA[SAMPLE_WIDTH-1:0]};
   // The low 32 bits of an unsigned product equal those of the signed
   // product. The full signed product always fits in 32 bits for
   // SAMPLE_WIDTH <= 16.
   assign xy_prod    = x_ext * y_ext;
   assign sum_x_nxt  = sum_x_q + x_ext;
   assign sum_y_nxt  = sum_y_q + y_ext;
   assign sum_xy_nxt = sum_xy_q + xy_prod;

`ifdef COV_MEAN_SUMSQ_EN
   logic [31:0] xx_prod, yy_prod, sum_xx_nxt, sum_yy_nxt;
   assign xx_prod    = x_ext * x_ext;
   assign yy_prod    = y_ext * y_ext;
   assign sum_xx_nxt = sum_xx_q + xx_prod;
   assign sum_yy_nxt = sum_yy_q + yy_prod;
`endif

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   always_comb begin
      rd_word = 32'd0;
      case (ar_idx)
         C_REG_CTRL:   rd_word = {30'd0, enable_q, 1'b0};
         C_REG_STATUS: rd_word = {30'd0, cnt_sat, ovf_q};
         C_REG_SX:     rd_word = sample_x_q;
         C_REG_SY:     rd_word = sample_y_q;
         C_REG_COUNT:  rd_word = count_q;
         C_REG_SUMX:   rd_word = sum_x_q;
         C_REG_SUMY:   rd_word = sum_y_q;
         C_REG_SUMXY:  rd_word = sum_xy_q;
`ifdef COV_MEAN_SUMSQ_EN
         C_REG_SUMXX:  rd_word = sum_xx_q;
         C_REG_SUMYY:  rd_word = sum_yy_q;
`endif
         default:      rd_word = 32'd0;
      endcase
   end

   always_comb begin
      awready_d  = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
      wready_d   = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
      bvalid_d   = bvalid_q;
      arready_d  = S_AXI_ARVALID && !rvalid_q && !arready_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      enable_d   = enable_q;
      ovf_d      = ovf_q;
      sample_x_d = sample_x_q;
      sample_y_d = sample_y_q;
      count_d    = count_q;
      sum_x_d    = sum_x_q;
      sum_y_d    = sum_y_q;
      sum_xy_d   = sum_xy_q;
`ifdef COV_MEAN_SUMSQ_EN
      sum_xx_d   = sum_xx_q;
      sum_yy_d   = sum_yy_q;
`endif

      if (wr_en)             bvalid_d = 1'b1;
      else if (S_AXI_BREADY) bvalid_d = 1'b0;

      if (rd_en) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_word;
      end else if (S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end

      if (wr_en) begin
         case (aw_idx)
            C_REG_CTRL: begin
               if (S_AXI_WSTRB[0]) begin
                  enable_d = S_AXI_WDATA[1];
                  if (S_AXI_WDATA[0]) begin
                     ovf_d    = 1'b0;
                     count_d  = 32'd0;
                     sum_x_d  = 32'd0;
                     sum_y_d  = 32'd0;
                     sum_xy_d = 32'd0;
`ifdef COV_MEAN_SUMSQ_EN
                     sum_xx_d = 32'd0;
                     sum_yy_d = 32'd0;
`endif
                  end
               end
            end
            C_REG_SX: sample_x_d = byte_merge(sample_x_q, S_AXI_WDATA, S_AXI_WSTRB);
            C_REG_SY: begin
               sample_y_d = byte_merge(sample_y_q, S_AXI_WDATA, S_AXI_WSTRB);
               if (enable_q && (S_AXI_WSTRB == 4'hF)) begin
                  if (cnt_sat) begin
                     // Counter exhausted: the pair is dropped and flagged.
                     ovf_d = 1'b1;
                  end else begin
                     count_d  = count_q + 32'd1;
                     sum_x_d  = sum_x_nxt;
                     sum_y_d  = sum_y_nxt;
                     sum_xy_d = sum_xy_nxt;
                     if (add_ovf(sum_x_q, x_ext, sum_x_nxt) ||
                         add_ovf(sum_y_q, y_ext, sum_y_nxt) ||
                         add_ovf(sum_xy_q, xy_prod, sum_xy_nxt))
                        ovf_d = 1'b1;
`ifdef COV_MEAN_SUMSQ_EN
                     sum_xx_d = sum_xx_nxt;
                     sum_yy_d = sum_yy_nxt;
                     if (add_ovf(sum_xx_q, xx_prod, sum_xx_nxt) ||
                         add_ovf(sum_yy_q, yy_prod, sum_yy_nxt))
                        ovf_d = 1'b1;
`endif
                  end
               end
            end
            default: ;  // read-only or unmapped: dropped, still OKAY
         endcase
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= 32'd0;
         enable_q   <= 1'b0;
         ovf_q      <= 1'b0;
         sample_x_q <= 32'd0;
         sample_y_q <= 32'd0;
         count_q    <= 32'd0;
         sum_x_q    <= 32'd0;
         sum_y_q    <= 32'd0;
         sum_xy_q   <= 32'd0;
`ifdef COV_MEAN_SUMSQ_EN
         sum_xx_q   <= 32'd0;
         sum_yy_q   <= 32'd0;
`endif
      end else begin
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         enable_q   <= enable_d;
         ovf_q      <= ovf_d;
         sample_x_q <= sample_x_d;
         sample_y_q <= sample_y_d;
         count_q    <= count_d;
         sum_x_q    <= sum_x_d;
         sum_y_q    <= sum_y_d;
         sum_xy_q   <= sum_xy_d;
`ifdef COV_MEAN_SUMSQ_EN
         sum_xx_q   <= sum_xx_d;
         sum_yy_q   <= sum_yy_d;
`endif
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_cov_mean_axil_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cov_mean_axil_acc
//  Purpose  : Self-checking bench for cov_mean_axil_acc. Directed scenarios
//             are followed by random register traffic. All traffic is checked
//             against a behavioural model of the register map.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cov_mean_axil_acc;

`ifdef COV_MEAN_SUMSQ_EN
   localparam int AW = 6;
`else
   localparam int AW = 5;
`endif
   localparam int     SW   = 16;
   localparam int     NREG = 2 ** (AW - 2);
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, wvalid, bready, arvalid, rready;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          awready, wready, bvalid, arready, rvalid;
   logic [1:0]    bresp, rresp;
   logic [31:0]   rdata;

   always #5 clk = ~clk;

   cov_mean_axil_acc u_dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (3'b000),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (3'b000),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------- reference model
   bit          m_en, m_ovf;
   logic [31:0] m_sx, m_sy, m_cnt, m_sumx, m_sumy, m_sumxy, m_sumxx, m_sumyy;

   task automatic model_clear();
      m_ovf = 0; m_cnt = 0; m_sumx = 0; m_sumy = 0; m_sumxy = 0;
      m_sumxx = 0; m_sumyy = 0;
   endtask

   task automatic model_reset();
      model_clear();
      m_en = 0; m_sx = 0; m_sy = 0;
   endtask

   // Exact signed sum; anything outside the int32 range is a signed overflow.
   function automatic logic [31:0] acc_add(input logic [31:0] acc, input longint v);
      longint s;
      s = longint'($signed(acc)) + v;
      if (s > MAXS || s < MINS) m_ovf = 1;
      return s[31:0];
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
      return r;
   endfunction

   task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
      longint x, y;
      logic [SW-1:0] lx, ly;
      case (idx)
         0: if (s[0]) begin
               m_en = d[1];
               if (d[0]) model_clear();
            end
         2: m_sx = merge(m_sx, d, s);
         3: begin
               m_sy = merge(m_sy, d, s);
               if (m_en && s == 4'hF) begin
                  if (m_cnt == 32'hFFFF_FFFF) m_ovf = 1;
                  else begin
                     lx = m_sx[SW-1:0];
                     ly = d[SW-1:0];
                     x = longint'($signed(lx));
                     y = longint'($signed(ly));
                     m_sumx  = acc_add(m_sumx, x);
                     m_sumy  = acc_add(m_sumy, y);
                     m_sumxy = acc_add(m_sumxy, x * y);
`ifdef COV_MEAN_SUMSQ_EN
                     m_sumxx = acc_add(m_sumxx, x * x);
                     m_sumyy = acc_add(m_sumyy, y * y);
`endif
                     m_cnt = m_cnt + 1;
                  end
               end
            end
         default: ;
      endcase
   endtask

   function automatic logic [31:0] model_read(input int idx);
      case (idx)
         0: return {30'd0, m_en, 1'b0};
         1: return {30'd0, m_cnt == 32'hFFFF_FFFF, m_ovf};
         2: return m_sx;
         3: return m_sy;
         4: return m_cnt;
         5: return m_sumx;
         6: return m_sumy;
         7: return m_sumxy;
`ifdef COV_MEAN_SUMSQ_EN
         8: return m_sumxx;
         9: return m_sumyy;
`endif
         default: return 32'd0;
      endcase
   endfunction

   // ------------------------------------------------------- bus tasks
   int          p_widx;
   logic [31:0] p_wdata;
   logic [3:0]  p_wstrb;
   logic [31:0] r_exp, r_last;

   function automatic logic [AW-1:0] mk_addr(input int idx, input logic [1:0] lo);
      logic [AW-1:0] a;
      a = AW'(idx * 4);
      a[1:0] = lo;
      return a;
   endfunction

   task automatic drive_w(input int idx, input logic [31:0] d, input logic [3:0] s);
      p_widx = idx; p_wdata = d; p_wstrb = s;
      awaddr = mk_addr(idx, 2'($urandom_range(0, 3)));
      wdata = d; wstrb = s;
      awvalid = 1; wvalid = 1;
   endtask

   task automatic wait_w_hs();
      int n;
      logic hs;
      n = 0;
      do begin @(negedge clk); n++; end while (!(awready && wready) && n < 20);
      hs = awready && wready;
      chk("aw_w_handshake", 32'(hs), 32'd1);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      if (hs) model_write(p_widx, p_wdata, p_wstrb);
   endtask

   task automatic wait_b(input int hold);
      chk("bvalid_set", 32'(bvalid), 32'd1);
      chk("bresp", 32'(bresp), 32'd0);
      repeat (hold) begin @(negedge clk); chk("bvalid_hold", 32'(bvalid), 32'd1); end
      @(negedge clk); bready = 1;
      @(posedge clk); #1; bready = 0;
      chk("bvalid_clr", 32'(bvalid), 32'd0);
   endtask

   task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s);
      drive_w(idx, d, s);
      wait_w_hs();
      wait_b(0);
   endtask

   task automatic drive_r(input int idx);
      p_widx = p_widx;
      araddr = mk_addr(idx, 2'($urandom_range(0, 3)));
      arvalid = 1;
      r_exp = model_read(idx);
   endtask

   task automatic wait_r_hs();
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 20);
      chk("ar_handshake", 32'(arready), 32'd1);
      @(posedge clk); #1;
      arvalid = 0;
   endtask

   task automatic wait_r(input int hold, input string tag);
      logic [31:0] first;
      chk("rvalid_set", 32'(rvalid), 32'd1);
      chk("rresp", 32'(rresp), 32'd0);
      chk(tag, rdata, r_exp);
      first = rdata;
      repeat (hold) begin
         @(negedge clk);
         chk("rvalid_hold", 32'(rvalid), 32'd1);
         chk("rdata_hold", rdata, first);
      end
      @(negedge clk); rready = 1;
      @(posedge clk); #1; rready = 0;
      chk("rvalid_clr", 32'(rvalid), 32'd0);
      r_last = first;
   endtask

   task automatic read_chk(input int idx, input string tag);
      drive_r(idx);
      wait_r_hs();
      wait_r(0, tag);
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < NREG; i++) read_chk(i, $sformatf("%s_reg%0d", tag, i));
   endtask

   function automatic logic [31:0] rnd_sample();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         1: r[15:0] = 16'h7FFF;
         2: r[15:0] = 16'h8000;
         default: ;
      endcase
      return r;
   endfunction

   // ------------------------------------------------------- stimulus
   initial begin
      rst_n = 0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      p_widx = 0; p_wdata = 0; p_wstrb = 0; r_exp = 0; r_last = 0;
      model_reset();

      repeat (3) begin
         @(negedge clk);
         chk("rst_bvalid", 32'(bvalid), 32'd0);
         chk("rst_rvalid", 32'(rvalid), 32'd0);
         chk("rst_ready", 32'({awready, wready, arready}), 32'd0);
         chk("rst_rdata", rdata, 32'd0);
      end
      rst_n = 1;
      read_all("reset");

      // Basic accumulation
      axi_write(0, 32'd2, 4'hF);
      axi_write(2, 32'd3, 4'hF);          axi_write(3, 32'd4, 4'hF);
      axi_write(2, 32'hFFFF_FFFE, 4'hF);  axi_write(3, 32'd5, 4'hF);
      axi_write(2, 32'd7, 4'hF);          axi_write(3, 32'hFFFF_FFFF, 4'hF);
      read_chk(4, "count");  chk("count_k", r_last, 32'd3);
      read_chk(5, "sumx");   chk("sumx_k", r_last, 32'd8);
      read_chk(6, "sumy");   chk("sumy_k", r_last, 32'd8);
      read_chk(7, "sumxy");  chk("sumxy_k", r_last, 32'hFFFF_FFFB);
      read_chk(1, "status"); chk("status_k", r_last, 32'd0);

      // Disabled commit and partial-strobe commit
      axi_write(0, 32'd0, 4'hF);
      axi_write(2, 32'd1, 4'hF); axi_write(3, 32'd1, 4'hF);
      read_chk(4, "dis_count"); chk("dis_count_k", r_last, 32'd3);
      read_chk(3, "dis_sy");    chk("dis_sy_k", r_last, 32'd1);
      axi_write(0, 32'd2, 4'hF);
      axi_write(3, 32'd5, 4'h3);
      read_chk(4, "part_count"); chk("part_count_k", r_last, 32'd3);
      read_chk(5, "part_sumx");

      // Back-pressure on B and R channels
      drive_w(2, 32'h0000_0011, 4'hF);
      wait_w_hs();
      drive_w(2, 32'h0000_0022, 4'hF);
      repeat (5) begin
         @(negedge clk);
         chk("bp_bvalid", 32'(bvalid), 32'd1);
         chk("bp_no_accept", 32'({awready, wready}), 32'd0);
      end
      @(negedge clk); bready = 1;
      @(posedge clk); #1; bready = 0;
      chk("bp_bvalid_clr", 32'(bvalid), 32'd0);
      wait_w_hs();
      wait_b(0);
      drive_r(2);
      wait_r_hs();
      wait_r(5, "bp_read");
      chk("bp_sx_k", r_last, 32'h0000_0022);

      // Overflow boundary on SUM_XY, then CLEAR with ENABLE
      axi_write(0, 32'd3, 4'hF);
      axi_write(2, 32'h0000_7FFF, 4'hF);
      axi_write(3, 32'h0000_7FFF, 4'hF);
      axi_write(3, 32'h0000_7FFF, 4'hF);
      read_chk(1, "ovf_pre"); chk("ovf_pre_k", r_last, 32'd0);
      axi_write(3, 32'h0000_7FFF, 4'hF);
      read_chk(1, "ovf_set"); chk("ovf_set_k", r_last, 32'd1);
      read_chk(7, "ovf_xy");  chk("ovf_xy_k", r_last, 32'hBFFD_0003);
      axi_write(0, 32'd3, 4'hF);
      read_chk(0, "clr_ctrl"); chk("clr_ctrl_k", r_last, 32'd2);
      read_chk(1, "clr_stat"); chk("clr_stat_k", r_last, 32'd0);
      read_chk(4, "clr_cnt");  chk("clr_cnt_k", r_last, 32'd0);
      read_chk(7, "clr_xy");   chk("clr_xy_k", r_last, 32'd0);
      read_chk(2, "clr_sx");   chk("clr_sx_k", r_last, 32'h0000_7FFF);

`ifdef COV_MEAN_SUMSQ_EN
      axi_write(2, 32'd3, 4'hF);          axi_write(3, 32'd4, 4'hF);
      axi_write(2, 32'hFFFF_FFFE, 4'hF);  axi_write(3, 32'd5, 4'hF);
      read_chk(8, "sumxx");  chk("sumxx_k", r_last, 32'd13);
      read_chk(9, "sumyy");  chk("sumyy_k", r_last, 32'd41);
      axi_write(10, 32'hDEAD_BEEF, 4'hF);
      read_chk(10, "unmapped"); chk("unmapped_k", r_last, 32'd0);
`endif

      // Random register traffic
      for (int it = 0; it < 300; it++) begin
         int op;
         op = $urandom_range(0, 9);
         case (op)
            0, 1, 2: axi_write(2, rnd_sample(), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
            3, 4, 5: axi_write(3, rnd_sample(), ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF);
            6: axi_write(0, {30'd0, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0},
                         ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF);
            7: axi_write($urandom_range(0, NREG - 1), $urandom, 4'($urandom));
            default: read_chk($urandom_range(0, NREG - 1), "rand_read");
         endcase
      end
      read_all("rand_end");

      // Reset while both responses are pending
      drive_r(5);
      wait_r_hs();
      drive_w(2, 32'h1234_5678, 4'hF);
      wait_w_hs();
      #2 rst_n = 0;
      model_reset();
      #1;
      chk("arst_bvalid", 32'(bvalid), 32'd0);
      chk("arst_rvalid", 32'(rvalid), 32'd0);
      @(negedge clk); rst_n = 1;
      read_all("post_reset");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
